fetch_stage: RTL and testbench



---
 rtl/fetch_stage_if.sv | 21 ++
 rtl/fetch_stage.sv | 68 ++++++
 tb/tb_fetch_stage.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - IF stage bus: imem port, controller/hazard inputs, IF/ID outputs
interface fetch_stage_if;
   logic [31:0] imemAddr;
   logic [31:0] imemData;
   logic [1:0]  pcSrc;
   logic        IFFlush;
   logic        stall;
   logic [31:0] ifidInstr;
   logic [31:0] ifidPc4;
   logic        ifidValid;

   modport master (
      output imemAddr, ifidInstr, ifidPc4, ifidValid,
      input  imemData, pcSrc, IFFlush, stall
   );

   modport slave (
      input  imemAddr, ifidInstr, ifidPc4, ifidValid,
      output imemData, pcSrc, IFFlush, stall
   );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS IF stage: PC, imem address and IF/ID register
// Option macro FETCH_JUMP_DELAY_SLOT_EN: keep the instruction after a jump as a delay slot.
module fetch_stage (
   input logic           clk,
   input logic           rstN,
   fetch_stage_if.master bus
);
   logic [31:0] pc;
   logic [31:0] pc4;
   logic [31:0] branch_target;
   logic [31:0] jump_target;
   logic [31:0] next_pc;
   logic [31:0] ifid_instr;
   logic [31:0] ifid_pc4;
   logic        ifid_valid;
   logic        squash;

   // Targets come from the instruction in decode, not the one being fetched.
   assign pc4           = pc + 32'd4;
   assign branch_target = ifid_pc4 + {{14{ifid_instr[15]}}, ifid_instr[15:0], 2'b00};
   assign jump_target   = {ifid_pc4[31:28], ifid_instr[25:0], 2'b00};

   always_comb begin
      next_pc = pc4;
      if (bus.stall) begin
         next_pc = pc;
      end else begin
         case (bus.pcSrc)
            2'd1:    next_pc = branch_target;
            2'd2:    next_pc = jump_target;
            default: next_pc = pc4;
         endcase
      end
   end

`ifdef FETCH_JUMP_DELAY_SLOT_EN
   assign squash = bus.IFFlush;
`else
   assign squash = bus.IFFlush | (bus.pcSrc == 2'd2);
`endif

   // Stall freezes IF/ID even when a squash is requested in the same cycle.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         pc         <= 32'h0;
         ifid_instr <= 32'h0;
         ifid_pc4   <= 32'h0;
         ifid_valid <= 1'b0;
      end else begin
         pc <= next_pc;
         if (!bus.stall) begin
            ifid_pc4 <= pc4;
            if (squash) begin
               ifid_instr <= 32'h0;
               ifid_valid <= 1'b0;
            end else begin
               ifid_instr <= bus.imemData;
               ifid_valid <= 1'b1;
            end
         end
      end
   end

   assign bus.imemAddr  = pc;
   assign bus.ifidInstr = ifid_instr;
   assign bus.ifidPc4   = ifid_pc4;
   assign bus.ifidValid = ifid_valid;
endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed bench for fetch_stage with a small instruction ROM
module tb_fetch_stage;
   localparam logic [31:0] I0  = 32'h2001_0001;
   localparam logic [31:0] I1  = 32'h2002_0002;
   localparam logic [31:0] BEQ = 32'h1000_FFFE;
   localparam logic [31:0] I3  = 32'h2003_0003;
   localparam logic [31:0] JL  = 32'h0800_0040;
   localparam logic [31:0] DS  = 32'h2004_0004;
   localparam logic [31:0] BW  = 32'h1000_FFF5;
   localparam logic [31:0] T   = 32'h2005_0005;
   localparam logic [31:0] W   = 32'h2006_0006;

   logic clk = 1'b0;
   logic rstN = 1'b0;
   logic ovr_en = 1'b1;
   logic [31:0] ovr_val = 32'hDEADBEEF;
   int n_checks = 0;
   int n_fail = 0;

   fetch_stage_if bus ();

   fetch_stage dut (
      .clk  (clk),
      .rstN (rstN),
      .bus  (bus.master)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_read(input logic [31:0] a);
      case (a)
         32'h0000_0000: return I0;
         32'h0000_0004: return I1;
         32'h0000_0008: return BEQ;
         32'h0000_000C: return I3;
         32'h0000_0010: return JL;
         32'h0000_0014: return DS;
         32'h0000_0020: return BW;
         32'h0000_0100: return T;
         32'hFFFF_FFF8: return JL;
         32'hFFFF_FFFC: return W;
         default:       return {16'hC0DE, a[15:0]};
      endcase
   endfunction

   function automatic logic [96:0] st(input logic [31:0] a, input logic [31:0] i,
                                      input logic [31:0] p, input logic v);
      return {a, i, p, v};
   endfunction

   assign bus.imemData = ovr_en ? ovr_val : mem_read(bus.imemAddr);

   wire [96:0] obs = {bus.imemAddr, bus.ifidInstr, bus.ifidPc4, bus.ifidValid};

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstN = 1'b0;
      bus.pcSrc = 2'd0;
      bus.IFFlush = 1'b0;
      bus.stall = 1'b0;
      #1;
      rstN = 1'b1;
   endtask

   task automatic test_reset();
      logic [96:0] exp;
      @(negedge clk);
      @(negedge clk);
      exp = st(32'h0, 32'h0, 32'h0, 1'b0);
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL reset_hold: got %h expected %h", obs, exp); end
      rstN = 1'b1;
      ovr_en = 1'b0;
      step();
      exp = st(32'h4, I0, 32'h4, 1'b1);
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL reset_first_edge: got %h expected %h", obs, exp); end
   endtask

   task automatic test_sequential();
      logic [96:0] exp;
      do_reset();
      for (int k = 1; k <= 4; k++) begin
         step();
         exp = st(32'(4 * k), mem_read(32'(4 * k - 4)), 32'(4 * k), 1'b1);
         n_checks++;
         if (obs !== exp) begin n_fail++; $display("FAIL seq_%0d: got %h expected %h", k, obs, exp); end
      end
   endtask

   task automatic test_stall();
      logic [96:0] exp;
      do_reset();
      step();
      step();
      bus.stall = 1'b1;
      for (int k = 0; k < 2; k++) begin
         step();
         exp = st(32'h8, I1, 32'h8, 1'b1);
         n_checks++;
         if (obs !== exp) begin n_fail++; $display("FAIL stall_%0d: got %h expected %h", k, obs, exp); end
      end
      bus.stall = 1'b0;
      step();
      exp = st(32'hC, BEQ, 32'hC, 1'b1);
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL stall_release: got %h expected %h", obs, exp); end
   endtask

   task automatic test_branch();
      logic [96:0] exp;
      do_reset();
      repeat (3) step();
      exp = st(32'hC, BEQ, 32'hC, 1'b1);
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL branch_setup: got %h expected %h", obs, exp); end
      bus.pcSrc = 2'd1;
      bus.IFFlush = 1'b1;
      step();
      exp = st(32'h4, 32'h0, 32'h10, 1'b0);
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL branch_taken: got %h expected %h", obs, exp); end
      bus.pcSrc = 2'd0;
      bus.IFFlush = 1'b0;
      step();
      exp = st(32'h8, I1, 32'h8, 1'b1);
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL branch_target_fetch: got %h expected %h", obs, exp); end
   endtask

   task automatic test_jump();
      logic [96:0] exp;
      do_reset();
      repeat (5) step();
      exp = st(32'h14, JL, 32'h14, 1'b1);
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL jump_setup: got %h expected %h", obs, exp); end
      bus.pcSrc = 2'd2;
      step();
`ifdef FETCH_JUMP_DELAY_SLOT_EN
      exp = st(32'h100, DS, 32'h18, 1'b1);
`else
      exp = st(32'h100, 32'h0, 32'h18, 1'b0);
`endif
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL jump_taken: got %h expected %h", obs, exp); end
      bus.pcSrc = 2'd0;
      step();
      exp = st(32'h104, T, 32'h104, 1'b1);
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL jump_target_fetch: got %h expected %h", obs, exp); end
   endtask

   task automatic test_reserved();
      logic [96:0] exp;
      do_reset();
      repeat (3) step();
      bus.pcSrc = 2'd3;
      step();
      exp = st(32'h10, I3, 32'h10, 1'b1);
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL pcsrc_reserved: got %h expected %h", obs, exp); end
      bus.pcSrc = 2'd0;
   endtask

   task automatic goto_top();
      do_reset();
      repeat (9) step();
      bus.pcSrc = 2'd1;
      bus.IFFlush = 1'b1;
      step();
      bus.pcSrc = 2'd0;
      bus.IFFlush = 1'b0;
   endtask

   task automatic test_wrap();
      logic [96:0] exp;
      do_reset();
      repeat (9) step();
      exp = st(32'h24, BW, 32'h24, 1'b1);
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL wrap_setup: got %h expected %h", obs, exp); end
      goto_top();
      exp = st(32'hFFFF_FFF8, 32'h0, 32'h28, 1'b0);
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL wrap_back_branch: got %h expected %h", obs, exp); end
      step();
      step();
      exp = st(32'h0, W, 32'h0, 1'b1);
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL wrap_zero: got %h expected %h", obs, exp); end
      step();
      exp = st(32'h4, I0, 32'h4, 1'b1);
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL wrap_after: got %h expected %h", obs, exp); end
   endtask

   task automatic test_jump_high();
      logic [96:0] exp;
      goto_top();
      step();
      exp = st(32'hFFFF_FFFC, JL, 32'hFFFF_FFFC, 1'b1);
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL jump_high_setup: got %h expected %h", obs, exp); end
      bus.pcSrc = 2'd2;
      step();
`ifdef FETCH_JUMP_DELAY_SLOT_EN
      exp = st(32'hF000_0100, W, 32'h0, 1'b1);
`else
      exp = st(32'hF000_0100, 32'h0, 32'h0, 1'b0);
`endif
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL jump_high: got %h expected %h", obs, exp); end
      bus.pcSrc = 2'd0;
   endtask

   task automatic test_stall_redirect_reset();
      logic [96:0] exp;
      do_reset();
      repeat (3) step();
      bus.stall = 1'b1;
      bus.pcSrc = 2'd1;
      step();
      exp = st(32'hC, BEQ, 32'hC, 1'b1);
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL stall_over_redirect: got %h expected %h", obs, exp); end
      #1;
      rstN = 1'b0;
      #1;
      exp = st(32'h0, 32'h0, 32'h0, 1'b0);
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL async_reset: got %h expected %h", obs, exp); end
      bus.stall = 1'b0;
      bus.pcSrc = 2'd0;
      #1;
      rstN = 1'b1;
      step();
      exp = st(32'h4, I0, 32'h4, 1'b1);
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL reset_drops_redirect: got %h expected %h", obs, exp); end
   endtask

   initial begin
      bus.pcSrc = 2'd0;
      bus.IFFlush = 1'b0;
      bus.stall = 1'b0;
      test_reset();
      test_sequential();
      test_stall();
      test_branch();
      test_jump();
      test_reserved();
      test_wrap();
      test_jump_high();
      test_stall_redirect_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got %0d checks, expected completion", n_checks);
      $fatal(1);
   end
endmodule
